// File: rtl/vga_fb_pkg.sv
// Shared constants and types for the VGA frame-buffer arbiter.
package vga_fb_pkg;

    localparam int FB_W    = 320;
    localparam int FB_H    = 240;
    localparam int ADDR_W  = 17;
    localparam int DATA_W  = 12;
    localparam int MEM_LAT = 1;
    localparam int STALL_W = 16;

    typedef enum logic [1:0] {IDLE, RD, WR} grant_t;

    // Linear frame-buffer word address of pixel (x, y).
    function automatic logic [ADDR_W-1:0] fb_addr(input int x, input int y);
        return ADDR_W'(y * FB_W + x);
    endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Reader, writer and RAM signals of the frame-buffer arbiter; slave is the arbiter's view.
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = vga_fb_pkg::ADDR_W,
    parameter int DATA_W = vga_fb_pkg::DATA_W
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_rdata,
        output rd_valid, rd_data, wr_ready, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_rdata,
        input  rd_valid, rd_data, wr_ready, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/vga_fb_rd_pipe.sv
// Read-return delay line: tracks issued reads through the RAM latency and registers the pixel.
module vga_fb_rd_pipe #(
    parameter int DATA_W  = 12,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data
);

    logic [MEM_LAT:0]   vld;
    logic [MEM_LAT+1:0] chain;

    // chain[MEM_LAT] marks the cycle in which mem_rdata carries the requested word.
    assign chain    = {vld, issue};
    assign rd_valid = chain[MEM_LAT+1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld     <= '0;
            rd_data <= '0;
        end else begin
            // NOTE: non-blocking so every stage shifts from the pre-edge value of its neighbour.
            vld <= chain[MEM_LAT:0];
            if (chain[MEM_LAT]) begin
                rd_data <= mem_rdata;
            end
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: scan-out reads always win, writer takes the spare slots.
module vga_fb_arbiter #(
    parameter int ADDR_W      = vga_fb_pkg::ADDR_W,
    parameter int DATA_W      = vga_fb_pkg::DATA_W,
    parameter int MEM_LAT     = vga_fb_pkg::MEM_LAT,
    parameter bit LOCK_VBLANK = 1'b0,
    parameter int STALL_W     = vga_fb_pkg::STALL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vblank,
    input  logic               frame_start,
    vga_fb_arbiter_if.slave    bus,
    output logic [STALL_W-1:0] stall_cnt
);
    import vga_fb_pkg::*;

    grant_t grant;
    logic   wr_fire;
    logic   rd_issue;

    assign bus.wr_ready = rst & ~bus.rd_req & (~LOCK_VBLANK | vblank);
    assign wr_fire      = bus.wr_valid & bus.wr_ready;
    assign rd_issue     = (grant == RD);

    // Grant FSM; the RAM strobes are registered together with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant         <= IDLE;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            if (bus.rd_req) begin
                grant        <= RD;
                bus.mem_en   <= 1'b1;
                bus.mem_we   <= 1'b0;
                bus.mem_addr <= bus.rd_addr;
            end else if (wr_fire) begin
                grant         <= WR;
                bus.mem_en    <= 1'b1;
                bus.mem_we    <= 1'b1;
                bus.mem_addr  <= bus.wr_addr;
                bus.mem_wdata <= bus.wr_data;
            end else begin
                grant      <= IDLE;
                bus.mem_en <= 1'b0;
                bus.mem_we <= 1'b0;
            end
        end
    end

    // A frame_start clear takes priority over a stall in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (frame_start) begin
            stall_cnt <= '0;
        end else if (bus.wr_valid && !bus.wr_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    vga_fb_rd_pipe #(
        .DATA_W  (DATA_W),
        .MEM_LAT (MEM_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .issue     (rd_issue),
        .mem_rdata (bus.mem_rdata),
        .rd_valid  (bus.rd_valid),
        .rd_data   (bus.rd_data)
    );

endmodule
